// File: rtl/tail_light_pkg.sv
// tail_light_pkg: shared state encoding and counter-width helper for the tail light sequencer
package tail_light_pkg;
  typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF} state_t;
  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/step_timer.sv
// step_timer: prescaler that pulses tick once every TICK_DIV cycles
// clk, reset (async active-low), clr (restart count at 0 on next edge) -> tick
module step_timer import tail_light_pkg::*; #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = cw(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] pcnt;
  assign tick = pcnt == LAST;
  always_ff @(posedge clk or negedge reset)
    if (!reset) pcnt <= '0;
    else pcnt <= (clr || tick) ? '0 : pcnt + 1'b1;
endmodule

// File: rtl/tail_light_sequencer.sv
// tail_light_sequencer: turn-signal and hazard sequencer driving left and right lamp banks
// clk, reset (async active-low), left/right/hazard requests -> lamp_l, lamp_r, busy (all registered)
module tail_light_sequencer import tail_light_pkg::*; #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  output logic [LAMPS-1:0] lamp_l,
  output logic [LAMPS-1:0] lamp_r,
  output logic             busy
);
  localparam int SW = cw(LAMPS + 1);
  localparam logic [SW-1:0] LAST = SW'(LAMPS);
  state_t state, state_n;
  logic [SW-1:0] step, step_n;
  logic [LAMPS-1:0] therm;
  logic tick;
  // The prescaler idles at 0 and restarts whenever the state changes, so every step is a full TICK_DIV.
  step_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk,
    .reset,
    .clr (state_n != state || state_n == IDLE),
    .tick
  );
  always_comb begin
    state_n = state;
    step_n  = step;
    case (state)
      IDLE: begin
        step_n  = '0;
        state_n = (hazard || (left && right)) ? HAZ_ON : left ? LEFT : right ? RIGHT : IDLE;
      end
      LEFT, RIGHT: if (tick) begin
        if (hazard) state_n = HAZ_ON;
        else if (step == LAST) state_n = IDLE;
        else step_n = step + 1'b1;
      end
      HAZ_ON:  if (tick) state_n = HAZ_OFF;
      HAZ_OFF: if (tick) state_n = hazard ? HAZ_ON : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Thermometer of the upcoming step; step == LAMPS is the dark step.
  for (genvar i = 0; i < LAMPS; i++) begin : g_therm
    assign therm[i] = step_n != LAST && SW'(i) <= step_n;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      step   <= '0;
      lamp_l <= '0;
      lamp_r <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      step   <= step_n;
      lamp_l <= state_n == HAZ_ON ? '1 : state_n == LEFT ? therm : '0;
      lamp_r <= state_n == HAZ_ON ? '1 : state_n == RIGHT ? therm : '0;
      busy   <= state_n != IDLE;
    end
endmodule

// File: tb/tb_tail_light_sequencer.sv
// tb_tail_light_sequencer: scoreboard bench for two sequencer configurations (3 lamps/4 cycles, 1 lamp/1 cycle)
module tb_tail_light_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic left = 1'b0, right = 1'b0, hazard = 1'b0;
  logic [2:0] l3, r3;
  logic b3, l1, r1, b1;
  always #5 clk = ~clk;

  tail_light_sequencer #(.LAMPS(3), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
    .lamp_l(l3), .lamp_r(r3), .busy(b3)
  );
  tail_light_sequencer #(.LAMPS(1), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
    .lamp_l(l1), .lamp_r(r1), .busy(b1)
  );

  typedef struct packed {logic [7:0] l; logic [7:0] r; logic b;} exp_t;
  exp_t q0[$], q1[$];
  int tests = 0, fails = 0;

  // Reference: mode 0 idle, 1 left, 2 right, 3 hazard (on = lit phase); age = cycles since the sequence/phase began.
  int mode[2], age[2];
  bit on[2];

  function automatic int lp(input int i); return i ? 1 : 3; endfunction
  function automatic int tp(input int i); return i ? 1 : 4; endfunction

  function automatic exp_t model_out(input int i);
    int L = lp(i);
    int k = age[i] / tp(i);
    logic [7:0] pat = (k < L) ? 8'((1 << (k + 1)) - 1) : 8'd0;
    logic [7:0] all = 8'((1 << L) - 1);
    exp_t e;
    e.b = mode[i] != 0;
    e.l = mode[i] == 3 ? (on[i] ? all : 8'd0) : mode[i] == 1 ? pat : 8'd0;
    e.r = mode[i] == 3 ? (on[i] ? all : 8'd0) : mode[i] == 2 ? pat : 8'd0;
    return e;
  endfunction

  task automatic advance(input int i, input bit l, input bit r, input bit h);
    int L = lp(i);
    int T = tp(i);
    case (mode[i])
      0: if (h || (l && r)) begin mode[i] = 3; on[i] = 1; age[i] = 0; end
         else if (l || r) begin mode[i] = l ? 1 : 2; age[i] = 0; end
      1, 2: if (age[i] % T == T - 1 && h) begin mode[i] = 3; on[i] = 1; age[i] = 0; end
            else if (age[i] == (L + 1) * T - 1) mode[i] = 0;
            else age[i]++;
      default: if (age[i] == T - 1) begin
                 age[i] = 0;
                 if (on[i]) on[i] = 0;
                 else if (h) on[i] = 1;
                 else mode[i] = 0;
               end else age[i]++;
    endcase
  endtask

  task automatic cyc(input bit l, input bit r, input bit h);
    @(posedge clk); #2;
    reset = 1'b1; left = l; right = r; hazard = h;
    for (int i = 0; i < 2; i++) advance(i, l, r, h);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  // One expectation for the immediate asynchronous clear, one for the following edge while still held.
  task automatic do_reset();
    @(posedge clk); #2;
    left = 1'b0; right = 1'b0; hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin mode[i] = 0; age[i] = 0; on[i] = 0; end
    repeat (2) begin q0.push_back(model_out(0)); q1.push_back(model_out(1)); end
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    exp_t e0, e1;
    @(posedge clk or negedge reset);
    #1;
    if (q0.size() > 0 && q1.size() > 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      chk("lamp_l[3x4]", {5'd0, l3}, e0.l);
      chk("lamp_r[3x4]", {5'd0, r3}, e0.r);
      chk("busy[3x4]",   {7'd0, b3}, {7'd0, e0.b});
      chk("lamp_l[1x1]", {7'd0, l1}, e1.l);
      chk("lamp_r[1x1]", {7'd0, r1}, e1.r);
      chk("busy[1x1]",   {7'd0, b1}, {7'd0, e1.b});
    end
  end

  initial begin
    bit l, r, h;
    for (int i = 0; i < 2; i++) begin mode[i] = 0; age[i] = 0; on[i] = 0; end
    repeat (2) @(posedge clk);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (20) cyc(0, 0, 0);
    repeat (40) cyc(0, 1, 0);
    repeat (20) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (8) cyc(0, 1, 0);
    repeat (24) cyc(0, 0, 0);
    repeat (20) cyc(1, 1, 0);
    repeat (12) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    repeat (4) cyc(0, 0, 1);
    repeat (15) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (9) cyc(0, 0, 0);
    do_reset();
    repeat (10) cyc(0, 0, 0);
    l = 0; r = 0; h = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        l = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        h = $urandom_range(0, 3) == 0;
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc(l, r, h);
    end
    repeat (3) @(posedge clk);
    #3;
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
